lcd_write_arbiter: RTL and testbench
====================================

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter NPORT, default 4, number of requester ports sharing the LCD writer.
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000, cycles allowed for lcd_done after lcd_req rises.
REQ-003 Parameter SKIP_DUP, default 1, enables the shadow-cache suppression of redundant writes.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_i  in  NPORT  per-port write request, held high by the requester until its done_o pulse.
REQ-007 row_i  in  2*NPORT  per-port row, port k at [2k+1:2k].
REQ-008 col_i  in  4*NPORT  per-port column, port k at [4k+3:4k].
REQ-009 char_i  in  8*NPORT  per-port ASCII character, port k at [8k+7:8k].
REQ-010 busy_o  out  NPORT  per-port busy indication back to the requester.
REQ-011 done_o  out  NPORT  per-port one-cycle completion pulse.
REQ-012 flush  in  1  invalidates every shadow-cache entry, e.g. after an LCD re-init.
REQ-013 lcd_req, lcd_row[1:0], lcd_col[3:0], lcd_char[7:0]  out  downstream write request and payload.
REQ-014 lcd_busy, lcd_done  in  1 each  downstream status; lcd_done is a one-cycle pulse.
REQ-015 gnt_o  out  clog2(NPORT)  currently or last granted port.
REQ-016 err_timeout  out  1  sticky flag, set on a downstream timeout.

Function
REQ-017 States: IDLE, ISSUE, SKIP, RELEASE.
REQ-018 IDLE: when any req_i bit is high and lcd_busy is low, pick a port round-robin, starting at last_gnt+1 and wrapping at NPORT.
REQ-019 On that grant, latch the port's row, col and char, and update gnt_o and last_gnt, all in the same cycle.
REQ-020 Grant with SKIP_DUP=1 and a valid shadow entry equal to the latched char -> SKIP; otherwise -> ISSUE.
REQ-021 ISSUE: lcd_req is high from the first ISSUE cycle, and the payload is stable while lcd_req is high.
REQ-022 ISSUE on lcd_done: next cycle lcd_req=0, done_o[g] pulses for exactly 1 cycle, shadow[row][col] is written and marked valid, state -> RELEASE.
REQ-023 ISSUE timeout: a 32-bit counter counts cycles in ISSUE.
REQ-024 On count reaching TIMEOUT_CYC: drop lcd_req, pulse done_o[g], set err_timeout, leave shadow unchanged, state -> RELEASE.
REQ-025 SKIP: pulse done_o[g] 1 cycle after the grant, never assert lcd_req, state -> RELEASE.
REQ-026 RELEASE: stay until req_i[g]==0, then -> IDLE, so one request is never served twice.
REQ-027 busy_o[k]=1 when state!=IDLE and k!=g.
REQ-028 busy_o[k]=1 when k==g and lcd_busy=1.
REQ-029 busy_o[k]=0 in all other cases.
REQ-030 Latency: grant to lcd_req is 1 cycle; skip completion is 1 cycle after grant.
REQ-031 Fairness: a continuously requesting port waits at most NPORT-1 other grants.
REQ-032 Simultaneous requests: lowest index at or after last_gnt+1 wins.
REQ-033 Requests that arrive during ISSUE, SKIP or RELEASE are held and arbitrated at the next IDLE.
REQ-034 flush and a shadow write in the same cycle: flush wins, and all entries are invalid.
REQ-035 req_i[g] dropping during ISSUE does not abort the downstream write; it completes and done_o still pulses.
REQ-036 The shadow is 2x16 entries, 8 bits each, plus a valid bit per entry.
REQ-037 Row values 2 and 3 are not cached; the lookup always misses and the write is always issued.

Reset
REQ-038 On rst_n low: state=IDLE; lcd_req=0; lcd_row, lcd_col, lcd_char, busy_o, done_o, gnt_o, err_timeout and the timeout counter = 0; last_gnt=NPORT-1; all shadow entries invalid.
REQ-039 Reset mid-ISSUE drops lcd_req immediately and issues no done_o pulse.
REQ-040 After reset release, the first grant goes to port 0 when port 0 is requesting.

Structure
REQ-041 Shared package lcd_pkg: NPORT default, row/col/char widths, state encoding, TIMEOUT_CYC default, ASCII space constant (32).
REQ-042 Sub-module lcd_rr_pick: combinational round-robin picker, inputs req vector and last_gnt, outputs valid and index.
REQ-043 Shadow cache and FSM are inside lcd_write_arbiter.

Verification
REQ-044 Single port: port0 writes 'A' (65) to row0 col3 -> lcd_req 1 cycle after grant, payload 0/3/65; on lcd_done, done_o[0] pulses once; a repeat write of 'A' to row0 col3 -> done_o pulse, lcd_req never rises.
REQ-045 Contention: ports 0-3 request together from reset -> downstream order 0,1,2,3; port0 re-requests during the sequence -> it is served after port3.
REQ-046 Timeout with TIMEOUT_CYC=100 and no lcd_done -> lcd_req falls after 100 cycles, done_o[g] pulses, err_timeout=1; the same char is issued again on the next write.
REQ-047 flush after writing 'E' to row0 col0 -> the next 'E' to row0 col0 drives lcd_req.
REQ-048 rst_n low mid-ISSUE -> lcd_req=0 asynchronously, no done_o pulse; after release, port0 is granted first.
REQ-049 Requester holds req_i high 5 cycles after done_o -> no second grant until it drops, busy_o of the other ports stays 1, and gnt_o stays unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write arbiter slice.
// Keep geometry here so the picker, cache and bench agree on field widths.
package lcd_pkg;

  localparam int NPORT_DEF       = 4;
  localparam int ROW_W           = 2;
  localparam int COL_W           = 4;
  localparam int CHAR_W          = 8;
  localparam int TIMEOUT_CYC_DEF = 1_000_000;
  localparam int SHADOW_DEPTH    = 32;

  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'd32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SKIP,
    ST_RELEASE
  } state_e;

  // Only rows 0 and 1 exist on the panel, so the cache is indexed by row bit 0.
  function automatic logic [4:0] shadowIdx(input logic [ROW_W-1:0] row,
                                           input logic [COL_W-1:0] col);
    return {row[0], col};
  endfunction

  function automatic logic rowCacheable(input logic [ROW_W-1:0] row);
    return !row[1];
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: scans from lastGnt+1 upward, wrapping at NPORT.
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int GW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req_i,
  input  logic [GW-1:0]    lastGnt_i,
  output logic             valid_o,
  output logic [GW-1:0]    idx_o
);

  int            cand;
  logic [GW-1:0] candIdx;

  // Walk offsets from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int off = NPORT; off >= 1; off--) begin
      cand    = (int'(lastGnt_i) + off) % NPORT;
      candIdx = cand[GW-1:0];
      if (req_i[candIdx]) begin
        valid_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one LCD character writer among NPORT requesters, with a shadow cache
// that completes writes of an unchanged character without touching the panel.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int NPORT       = NPORT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int SKIP_DUP    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORT-1:0]         req_i,
  input  logic [2*NPORT-1:0]       row_i,
  input  logic [4*NPORT-1:0]       col_i,
  input  logic [8*NPORT-1:0]       char_i,
  output logic [NPORT-1:0]         busy_o,
  output logic [NPORT-1:0]         done_o,
  input  logic                     flush,
  output logic                     lcd_req,
  output logic [1:0]               lcd_row,
  output logic [3:0]               lcd_col,
  output logic [7:0]               lcd_char,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic [$clog2(NPORT)-1:0] gnt_o,
  output logic                     err_timeout
);

  localparam int          GW      = $clog2(NPORT);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [GW-1:0]       lastGnt_q, lastGnt_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [NPORT-1:0]    done_q, done_d;
  logic                errTo_q, errTo_d;
  logic                shadowWr;

  logic [CHAR_W-1:0]       shadowChar_q [SHADOW_DEPTH];
  logic [SHADOW_DEPTH-1:0] shadowValid_q;

  logic [ROW_W-1:0]  rowArr  [NPORT];
  logic [COL_W-1:0]  colArr  [NPORT];
  logic [CHAR_W-1:0] charArr [NPORT];

  logic              pickValid;
  logic [GW-1:0]     pickIdx;
  logic [ROW_W-1:0]  pickRow;
  logic [COL_W-1:0]  pickCol;
  logic [CHAR_W-1:0] pickChar;
  logic [4:0]        lookIdx;
  logic              dupHit;

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      rowArr[k]  = row_i[2*k +: 2];
      colArr[k]  = col_i[4*k +: 4];
      charArr[k] = char_i[8*k +: 8];
    end
  end

  lcd_rr_pick #(
    .NPORT (NPORT),
    .GW    (GW)
  ) u_pick (
    .req_i     (req_i),
    .lastGnt_i (lastGnt_q),
    .valid_o   (pickValid),
    .idx_o     (pickIdx)
  );

  always_comb begin
    pickRow  = rowArr[pickIdx];
    pickCol  = colArr[pickIdx];
    pickChar = charArr[pickIdx];
    lookIdx  = shadowIdx(pickRow, pickCol);
    dupHit   = (SKIP_DUP != 0) && rowCacheable(pickRow) &&
               shadowValid_q[lookIdx] && (shadowChar_q[lookIdx] == pickChar);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      lastGnt_q <= GW'(NPORT - 1);
      row_q     <= '0;
      col_q     <= '0;
      char_q    <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      errTo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      lastGnt_q <= lastGnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      char_q    <= char_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      errTo_q   <= errTo_d;
    end
  end

  // lcd_done wins over a timeout landing on the same cycle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    lastGnt_d = lastGnt_q;
    row_d     = row_q;
    col_d     = col_q;
    char_d    = char_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    errTo_d   = errTo_q;
    shadowWr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pickValid && !lcd_busy) begin
          gnt_d     = pickIdx;
          lastGnt_d = pickIdx;
          row_d     = pickRow;
          col_d     = pickCol;
          char_d    = pickChar;
          cnt_d     = '0;
          state_d   = dupHit ? ST_SKIP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (lcd_done) begin
          done_d[gnt_q] = 1'b1;
          shadowWr      = 1'b1;
          cnt_d         = '0;
          state_d       = ST_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          done_d[gnt_q] = 1'b1;
          errTo_d       = 1'b1;
          cnt_d         = '0;
          state_d       = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_SKIP: begin
        done_d[gnt_q] = 1'b1;
        state_d       = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!req_i[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A flush on the same cycle as a completing write leaves the whole cache invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowValid_q <= '0;
      for (int i = 0; i < SHADOW_DEPTH; i++) shadowChar_q[i] <= ASCII_SPACE;
    end else if (flush) begin
      shadowValid_q <= '0;
    end else if (shadowWr && rowCacheable(row_q)) begin
      shadowValid_q[shadowIdx(row_q, col_q)] <= 1'b1;
      shadowChar_q[shadowIdx(row_q, col_q)]  <= char_q;
    end
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      busy_o[k] = ((state_q != ST_IDLE) && (GW'(k) != gnt_q)) ||
                  ((GW'(k) == gnt_q) && lcd_busy);
    end
  end

  assign lcd_req     = (state_q == ST_ISSUE);
  assign lcd_row     = row_q;
  assign lcd_col     = col_q;
  assign lcd_char    = char_q;
  assign done_o      = done_q;
  assign gnt_o       = gnt_q;
  assign err_timeout = errTo_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: four ports, 100-cycle downstream timeout.
module tb_lcd_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_i = '0;
  logic [7:0]  row_i = '0;
  logic [15:0] col_i = '0;
  logic [31:0] char_i = '0;
  logic [3:0]  busy_o;
  logic [3:0]  done_o;
  logic        flush = 1'b0;
  logic        lcd_req;
  logic [1:0]  lcd_row;
  logic [3:0]  lcd_col;
  logic [7:0]  lcd_char;
  logic        lcd_busy = 1'b0;
  logic        lcd_done = 1'b0;
  logic [1:0]  gnt_o;
  logic        err_timeout;

  int assertCount = 0;
  int failCount   = 0;

  lcd_write_arbiter #(
    .NPORT       (4),
    .TIMEOUT_CYC (100),
    .SKIP_DUP    (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .row_i       (row_i),
    .col_i       (col_i),
    .char_i      (char_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .flush       (flush),
    .lcd_req     (lcd_req),
    .lcd_row     (lcd_row),
    .lcd_col     (lcd_col),
    .lcd_char    (lcd_char),
    .lcd_busy    (lcd_busy),
    .lcd_done    (lcd_done),
    .gnt_o       (gnt_o),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic [1:0] row,
                               input logic [3:0] col, input logic [7:0] ch);
    row_i[port*2 +: 2]  = row;
    col_i[port*4 +: 4]  = col;
    char_i[port*8 +: 8] = ch;
    req_i[port]         = 1'b1;
  endtask

  task automatic waitReq(input string tag, output int lat);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (lcd_req) begin
        lat = i;
        break;
      end
      tick();
    end
    checkOutput({tag, " lcd_req seen"}, 32'(lat >= 0), 1);
  endtask

  // Pulse lcd_done, check the completion, release the request and return to IDLE.
  task automatic completeWrite(input int port, input string tag);
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    checkOutput({tag, " done_o"}, done_o, 32'(1 << port));
    checkOutput({tag, " lcd_req low"}, lcd_req, 0);
    req_i[port] = 1'b0;
    tick();
  endtask

  task automatic issueWrite(input int port, input logic [1:0] row, input logic [3:0] col,
                            input logic [7:0] ch, input string tag);
    int lat;
    applyStimulus(port, row, col, ch);
    waitReq(tag, lat);
    checkOutput({tag, " gnt"}, gnt_o, port);
    checkOutput({tag, " row"}, lcd_row, row);
    checkOutput({tag, " col"}, lcd_col, col);
    checkOutput({tag, " char"}, lcd_char, ch);
    completeWrite(port, tag);
  endtask

  task automatic expectSkip(input int port, input logic [1:0] row, input logic [3:0] col,
                            input logic [7:0] ch, input string tag);
    applyStimulus(port, row, col, ch);
    tick();
    checkOutput({tag, " no req at grant"}, lcd_req, 0);
    checkOutput({tag, " no done at grant"}, done_o, 0);
    tick();
    checkOutput({tag, " skip done_o"}, done_o, 32'(1 << port));
    checkOutput({tag, " no req at done"}, lcd_req, 0);
    req_i[port] = 1'b0;
    tick();
    checkOutput({tag, " no req after"}, lcd_req, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int hiCount;
    int expOrder [5] = '{0, 1, 2, 3, 0};
    int expCol   [5] = '{0, 1, 2, 3, 8};

    $display("[TB] reset values");
    #12;
    checkOutput("rst lcd_req", lcd_req, 0);
    checkOutput("rst done_o", done_o, 0);
    checkOutput("rst busy_o", busy_o, 0);
    checkOutput("rst gnt_o", gnt_o, 0);
    checkOutput("rst err_timeout", err_timeout, 0);
    checkOutput("rst payload", {lcd_row, lcd_col, lcd_char}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single port write and duplicate skip");
    applyStimulus(0, 2'd0, 4'd3, 8'd65);
    waitReq("A first", lat);
    checkOutput("A latency", lat, 1);
    checkOutput("A gnt", gnt_o, 0);
    checkOutput("A payload", {lcd_row, lcd_col, lcd_char}, {2'd0, 4'd3, 8'd65});
    checkOutput("A busy others", busy_o, 4'b1110);
    tick();
    tick();
    checkOutput("A req held", lcd_req, 1);
    lcd_busy = 1'b1;
    #1;
    checkOutput("A busy with lcd_busy", busy_o, 4'b1111);
    lcd_busy = 1'b0;
    #1;
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    checkOutput("A done_o", done_o, 4'b0001);
    checkOutput("A lcd_req dropped", lcd_req, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold done_o", done_o, 0);
      checkOutput("hold gnt", gnt_o, 0);
      checkOutput("hold busy", busy_o, 4'b1110);
      checkOutput("hold lcd_req", lcd_req, 0);
    end
    req_i[0] = 1'b0;
    tick();
    checkOutput("A idle busy", busy_o, 0);
    expectSkip(0, 2'd0, 4'd3, 8'd65, "A repeat");

    $display("[TB] contention from reset");
    rst_n = 1'b0;
    #3;
    for (int p = 0; p < 4; p++) applyStimulus(p, 2'd1, 4'(p), 8'(97 + p));
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      waitReq("order", lat);
      checkOutput("order gnt", gnt_o, expOrder[n]);
      checkOutput("order col", lcd_col, expCol[n]);
      if (n == 1) applyStimulus(0, 2'd1, 4'd8, 8'd97);
      completeWrite(expOrder[n], "order");
    end

    $display("[TB] downstream timeout");
    applyStimulus(1, 2'd0, 4'd5, 8'd84);
    waitReq("T timeout", lat);
    checkOutput("T gnt", gnt_o, 1);
    hiCount = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!lcd_req) break;
      hiCount++;
    end
    checkOutput("T req high cycles", hiCount, 100);
    checkOutput("T done_o", done_o, 4'b0010);
    checkOutput("T err_timeout", err_timeout, 1);
    req_i[1] = 1'b0;
    tick();
    issueWrite(1, 2'd0, 4'd5, 8'd84, "T reissue");
    checkOutput("T err sticky", err_timeout, 1);

    $display("[TB] flush behaviour");
    applyStimulus(2, 2'd0, 4'd0, 8'd69);
    waitReq("E flush+write", lat);
    flush    = 1'b1;
    lcd_done = 1'b1;
    tick();
    flush    = 1'b0;
    lcd_done = 1'b0;
    checkOutput("E flush+write done", done_o, 4'b0100);
    req_i[2] = 1'b0;
    tick();
    issueWrite(2, 2'd0, 4'd0, 8'd69, "E after coincident flush");
    expectSkip(2, 2'd0, 4'd0, 8'd69, "E cached");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issueWrite(2, 2'd0, 4'd0, 8'd69, "E after flush");

    $display("[TB] rows 2 and 3 never cached");
    issueWrite(3, 2'd2, 4'd1, 8'd82, "R row2 first");
    issueWrite(3, 2'd2, 4'd1, 8'd82, "R row2 repeat");

    $display("[TB] reset during ISSUE");
    applyStimulus(1, 2'd1, 4'd4, 8'd90);
    waitReq("Z issue", lat);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("Z async lcd_req", lcd_req, 0);
    checkOutput("Z no done", done_o, 0);
    checkOutput("Z gnt cleared", gnt_o, 0);
    req_i = '0;
    applyStimulus(2, 2'd1, 4'd6, 8'd66);
    applyStimulus(0, 2'd0, 4'd0, 8'd69);
    tick();
    checkOutput("Z no done in reset", done_o, 0);
    rst_n = 1'b1;
    waitReq("Z first after reset", lat);
    checkOutput("Z first gnt", gnt_o, 0);
    checkOutput("Z first char", lcd_char, 69);
    completeWrite(0, "Z port0");
    waitReq("Z second", lat);
    checkOutput("Z second gnt", gnt_o, 2);
    completeWrite(2, "Z port2");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
